mux_n_skid: RTL and testbench

- Parametrised N-to-1 data selector with a registered, back-pressure-aware output stage for the pipelined CPU datapath.
- Selects one of NUM_SRC operand sources. Latches the result plus an error tag into a 2-entry skid buffer and presents it downstream with a valid/ready handshake.
- Supports pipeline flush.
- Used between forwarding sources and the EX-stage operand register, and anywhere a selected value must survive a downstream stall.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/mux_n_skid_if.sv | 31 +++
 rtl/skid_buffer.sv | 89 ++++++++
 rtl/mux_n_skid.sv | 49 ++++
 tb/tb_mux_n_skid.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath package: data width, forwarding source indices and
// the state encoding of the output skid buffer.
package cpu_pkg;

    localparam int XLEN = 32;

    // Forwarding source indices as seen by the operand selector
    localparam int FWD_RF  = 0;
    localparam int FWD_EX  = 1;
    localparam int FWD_MEM = 2;
    localparam int FWD_WB  = 3;

    // Encoding mirrors {skid_vld, main_vld}
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b11
    } buf_state_e;

endpackage

// File: rtl/mux_n_skid_if.sv
// Upstream selection and downstream valid/ready bundle of mux_n_skid.
// master drives the sources and consumes the output, slave is the block.
interface mux_n_skid_if
    import cpu_pkg::*;
#(
    parameter int WIDTH   = XLEN,
    parameter int NUM_SRC = 4
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic [NUM_SRC*WIDTH-1:0] src;
    logic [SEL_W-1:0]         sel;
    logic                     in_valid;
    logic                     in_ready;
    logic                     flush;
    logic [WIDTH-1:0]         out_data;
    logic                     out_err;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output src, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  src, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_err, out_valid
    );

endinterface

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer. Entries leave in arrival order; the
// skid entry only ever moves into main, never bypasses it.
module skid_buffer
    import cpu_pkg::*;
#(
    parameter int W = XLEN + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    buf_state_e   state;
    logic         main_vld;
    logic         skid_vld;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         pop;

    assign accept    = in_valid & in_ready;
    assign pop       = main_vld & out_ready;
    assign out_valid = main_vld;

    // Occupancy FSM with registered valid/ready flags and payload registers
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // sees the pre-edge values of its neighbours, regardless of order.
        if (rst) begin
            state     <= BUF_EMPTY;
            main_vld  <= 1'b0;
            skid_vld  <= 1'b0;
            in_ready  <= 1'b1;
            // NOTE: payload registers are reset too because the head is
            // visible on out_data and must read 0 straight after reset.
            out_data  <= '0;
            skid_data <= '0;
        end else if (flush) begin
            // Payloads are left alone: invalid entries are don't-care
            state    <= BUF_EMPTY;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        out_data <= in_data;
                        main_vld <= 1'b1;
                        state    <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && pop) begin
                        out_data <= in_data;
                    end else if (accept) begin
                        skid_data <= in_data;
                        skid_vld  <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= BUF_FULL;
                    end else if (pop) begin
                        main_vld <= 1'b0;
                        state    <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (pop) begin
                        out_data <= skid_data;
                        skid_vld <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= BUF_ONE;
                    end
                end
                default: begin
                    state    <= BUF_EMPTY;
                    main_vld <= 1'b0;
                    skid_vld <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mux_n_skid.sv
// N-to-1 operand selector with out-of-range error tag, followed by a
// two-entry skid buffer so the selected value survives downstream stalls.
module mux_n_skid
    import cpu_pkg::*;
#(
    parameter int WIDTH   = XLEN,
    parameter int NUM_SRC = 4
) (
    input  logic         clk,
    input  logic         rst,
    mux_n_skid_if.slave  bus
);

    localparam int SEL_W = $clog2(NUM_SRC);

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic [WIDTH:0]   head;

    // Combinational source select; an index past the last source yields 0 + err
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        sel_data = '0;
        sel_err  = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                sel_data = bus.src[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    skid_buffer #(.W(WIDTH + 1)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_data   ({sel_err, sel_data}),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .out_data  (head),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

    assign bus.out_err  = head[WIDTH];
    assign bus.out_data = head[WIDTH-1:0];

endmodule

// File: tb/tb_mux_n_skid.sv
// Scoreboard bench for mux_n_skid: a 4-source and a 3-source instance get
// identical stimulus; each has its own expected-entry queue.
module tb_mux_n_skid;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_n_skid_if #(.WIDTH(32), .NUM_SRC(4)) bus4 ();
    mux_n_skid_if #(.WIDTH(32), .NUM_SRC(3)) bus3 ();

    mux_n_skid #(.WIDTH(32), .NUM_SRC(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    mux_n_skid #(.WIDTH(32), .NUM_SRC(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] src_v [4];
    logic [32:0] sb4 [$];
    logic [32:0] sb3 [$];
    logic        fresh [2];
    logic        armed = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [32:0] exp_word(input int s, input int nsrc);
        if (s < nsrc) return {1'b0, src_v[s]};
        return {1'b1, 32'h0};
    endfunction

    task automatic observe(input int d, input logic ov, input logic ir,
                           input logic [31:0] od, input logic oe);
        string nm;
        int n;
        logic [32:0] head;
        nm = (d == 0) ? "n4" : "n3";
        n = (d == 0) ? sb4.size() : sb3.size();
        check({nm, ".out_valid"}, 64'(ov), 64'(n > 0));
        check({nm, ".in_ready"}, 64'(ir), 64'(n < 2));
        if (n > 0) begin
            head = (d == 0) ? sb4[0] : sb3[0];
            check({nm, ".out_data"}, 64'(od), 64'(head[31:0]));
            check({nm, ".out_err"}, 64'(oe), 64'(head[32]));
        end else if (fresh[d]) begin
            check({nm, ".rst_data"}, 64'(od), 64'h0);
            check({nm, ".rst_err"}, 64'(oe), 64'h0);
        end
    endtask

    task automatic model(input int d, input int nsrc, input logic iv, input int s,
                         input logic ordy, input logic fl, input logic rs);
        int n;
        logic acc;
        logic pp;
        n = (d == 0) ? sb4.size() : sb3.size();
        acc = iv && (n < 2);
        pp = (n > 0) && ordy;
        if (rs || fl) begin
            if (d == 0) sb4.delete(); else sb3.delete();
            if (rs) fresh[d] = 1'b1;
        end else begin
            if (pp) begin
                if (d == 0) void'(sb4.pop_front()); else void'(sb3.pop_front());
            end
            if (acc) begin
                if (d == 0) sb4.push_back(exp_word(s, nsrc));
                else        sb3.push_back(exp_word(s, nsrc));
                fresh[d] = 1'b0;
            end
        end
    endtask

    // One clock cycle: check state left by the previous edge, then drive
    task automatic step(input logic iv, input int s, input logic ordy,
                        input logic fl = 1'b0, input logic rs = 1'b0);
        @(negedge clk);
        if (armed) begin
            observe(0, bus4.out_valid, bus4.in_ready, bus4.out_data, bus4.out_err);
            observe(1, bus3.out_valid, bus3.in_ready, bus3.out_data, bus3.out_err);
        end
        rst = rs;
        bus4.src = {src_v[3], src_v[2], src_v[1], src_v[0]};
        bus3.src = {src_v[2], src_v[1], src_v[0]};
        bus4.sel = 2'(s);       bus3.sel = 2'(s);
        bus4.in_valid = iv;     bus3.in_valid = iv;
        bus4.out_ready = ordy;  bus3.out_ready = ordy;
        bus4.flush = fl;        bus3.flush = fl;
        model(0, 4, iv, s, ordy, fl, rs);
        model(1, 3, iv, s, ordy, fl, rs);
        if (rs) armed = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) src_v[k] = 32'(k + 1);
        fresh[0] = 1'b1;
        fresh[1] = 1'b1;

        // Reset, then a single transfer of source 2
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1);
        step(1, 2, 1);
        step(0, 0, 1);
        step(0, 0, 1);

        // Streaming, one accept per cycle
        for (int i = 0; i < 4; i++) step(1, i, 1);
        step(0, 0, 1);
        step(0, 0, 1);

        // Back-pressure into FULL, blocked input while full, then drain
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 2, 0);
        step(1, 2, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);

        // Out-of-range on the 3-source instance, then back in range
        step(1, 3, 1);
        step(1, 1, 1);
        step(0, 0, 1);
        step(0, 0, 1);

        // Flush in FULL with a same-cycle input that must be dropped
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 3, 0, 1);
        step(0, 0, 1);
        step(1, 2, 1);
        step(0, 0, 1);

        // Flush with a same-cycle pop in ONE
        step(1, 3, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1);

        // Reset asserted in FULL, then a normal transfer
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 2, 0, 0, 1);
        step(0, 0, 1);
        step(1, 2, 1);
        step(0, 0, 1);
        step(0, 0, 1);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) src_v[k] = $urandom;
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
